// File: rtl/ysyx_23060240_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module : ysyx_23060240_bus_pkg
// Brief  : Shared encodings for the core memory-bus arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package ysyx_23060240_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } arb_state_e;

    localparam logic MID_IFU = 1'b0;
    localparam logic MID_LSU = 1'b1;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060240_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : ysyx_23060240_rr_pick
// Brief  : Two-way round-robin pick; on a tie the master not served last wins.
// Rev    : 1.0  initial release
// ============================================================================
module ysyx_23060240_rr_pick
    import ysyx_23060240_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = MID_IFU;
        if (req == 2'b11) begin
            grant = ~last;
        end else if (req[1]) begin
            grant = MID_LSU;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060240_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ysyx_23060240_mem_arbiter
// Brief  : Shares one memory port between IFU (m0) and LSU (m1), one
//          outstanding transaction, with response timeout.
// Rev    : 1.0  initial release
// ============================================================================
module ysyx_23060240_mem_arbiter
    import ysyx_23060240_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_req_addr,
    input  logic                m0_req_wen,
    input  logic [DATA_W-1:0]   m0_req_wdata,
    input  logic [DATA_W/8-1:0] m0_req_wstrb,
    output logic                m0_rsp_valid,
    input  logic                m0_rsp_ready,
    output logic [DATA_W-1:0]   m0_rsp_rdata,
    output logic                m0_rsp_err,
    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_req_addr,
    input  logic                m1_req_wen,
    input  logic [DATA_W-1:0]   m1_req_wdata,
    input  logic [DATA_W/8-1:0] m1_req_wstrb,
    output logic                m1_rsp_valid,
    input  logic                m1_rsp_ready,
    output logic [DATA_W-1:0]   m1_rsp_rdata,
    output logic                m1_rsp_err,
    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_req_addr,
    output logic                s_req_wen,
    output logic [DATA_W-1:0]   s_req_wdata,
    output logic [DATA_W/8-1:0] s_req_wstrb,
    input  logic                s_rsp_valid,
    output logic                s_rsp_ready,
    input  logic [DATA_W-1:0]   s_rsp_rdata,
    input  logic                s_rsp_err,
    output logic                busy,
    output logic                grant
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYC);

    arb_state_e       state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             wen_q, wen_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             pick_id;

    logic                sel_req_valid;
    logic [ADDR_W-1:0]   sel_req_addr;
    logic                sel_req_wen;
    logic [DATA_W-1:0]   sel_req_wdata;
    logic [DATA_W/8-1:0] sel_req_wstrb;
    logic                sel_rsp_ready;
    logic                g_req_ready;
    logic                g_rsp_valid;
    logic [DATA_W-1:0]   g_rsp_rdata;
    logic                g_rsp_err;

    ysyx_23060240_rr_pick u_pick (
        .req   ({m1_req_valid, m0_req_valid}),
        .last  (last_q),
        .grant (pick_id)
    );

    always_comb begin
        sel_req_valid = grant_q ? m1_req_valid : m0_req_valid;
        sel_req_addr  = grant_q ? m1_req_addr  : m0_req_addr;
        sel_req_wen   = grant_q ? m1_req_wen   : m0_req_wen;
        sel_req_wdata = grant_q ? m1_req_wdata : m0_req_wdata;
        sel_req_wstrb = grant_q ? m1_req_wstrb : m0_req_wstrb;
        sel_rsp_ready = grant_q ? m1_rsp_ready : m0_rsp_ready;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        wen_d       = wen_q;
        to_cnt_d    = to_cnt_q;
        cnt_inc     = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
        s_req_valid = 1'b0;
        s_req_addr  = '0;
        s_req_wen   = 1'b0;
        s_req_wdata = '0;
        s_req_wstrb = '0;
        s_rsp_ready = 1'b0;
        g_req_ready = 1'b0;
        g_rsp_valid = 1'b0;
        g_rsp_rdata = '0;
        g_rsp_err   = RSP_OK;
        case (state_q)
            ST_IDLE: begin
                // Stray responses arriving here are drained, never forwarded.
                s_rsp_ready = 1'b1;
                if (m0_req_valid || m1_req_valid) begin
                    grant_d = pick_id;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                s_req_valid = sel_req_valid;
                s_req_addr  = sel_req_addr;
                s_req_wen   = sel_req_wen;
                s_req_wdata = sel_req_wdata;
                s_req_wstrb = sel_req_wstrb;
                g_req_ready = s_req_ready;
                if (sel_req_valid && s_req_ready) begin
                    state_d  = ST_RESP;
                    to_cnt_d = '0;
                    wen_d    = sel_req_wen;
                end else if (!sel_req_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                g_rsp_valid = s_rsp_valid;
                g_rsp_err   = s_rsp_err;
                g_rsp_rdata = (wen_q || s_rsp_err) ? '0 : s_rsp_rdata;
                s_rsp_ready = sel_rsp_ready;
                if (s_rsp_valid && sel_rsp_ready) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end else if (!s_rsp_valid && (TIMEOUT_CYC != 0)) begin
                    to_cnt_d = cnt_inc;
                    if (cnt_inc == TO_MAX) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                g_rsp_valid = 1'b1;
                g_rsp_err   = RSP_ERR;
                if (sel_rsp_ready) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= MID_IFU;
            last_q   <= MID_LSU;
            wen_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            wen_q    <= wen_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        m0_req_ready = (grant_q == MID_IFU) && g_req_ready;
        m0_rsp_valid = (grant_q == MID_IFU) && g_rsp_valid;
        m0_rsp_err   = (grant_q == MID_IFU) && g_rsp_err;
        m0_rsp_rdata = (grant_q == MID_IFU) ? g_rsp_rdata : '0;
        m1_req_ready = (grant_q == MID_LSU) && g_req_ready;
        m1_rsp_valid = (grant_q == MID_LSU) && g_rsp_valid;
        m1_rsp_err   = (grant_q == MID_LSU) && g_rsp_err;
        m1_rsp_rdata = (grant_q == MID_LSU) ? g_rsp_rdata : '0;
    end

    assign busy  = (state_q != ST_IDLE);
    assign grant = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060240_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_ysyx_23060240_mem_arbiter
// Brief  : Directed bench with a transaction-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ysyx_23060240_mem_arbiter;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  mv, mwen, mrr;
    logic [31:0] ma [2];
    logic [31:0] mwd [2];
    logic [3:0]  mws [2];
    logic        m0_rdy, m1_rdy, m0_rv, m1_rv, m0_re, m1_re;
    logic [31:0] m0_rd, m1_rd;
    logic        s_req_valid, s_req_ready, s_req_wen, s_rsp_valid, s_rsp_ready, s_rsp_err;
    logic [31:0] s_req_addr, s_req_wdata, s_rsp_rdata;
    logic [3:0]  s_req_wstrb;
    logic        busy, grant;

    wire [1:0]  mrdy = {m1_rdy, m0_rdy};
    wire [1:0]  mrv  = {m1_rv, m0_rv};
    wire [1:0]  mre  = {m1_re, m0_re};
    wire [63:0] mrd  = {m1_rd, m0_rd};

    ysyx_23060240_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(mv[0]), .m0_req_ready(m0_rdy), .m0_req_addr(ma[0]), .m0_req_wen(mwen[0]),
        .m0_req_wdata(mwd[0]), .m0_req_wstrb(mws[0]), .m0_rsp_valid(m0_rv), .m0_rsp_ready(mrr[0]),
        .m0_rsp_rdata(m0_rd), .m0_rsp_err(m0_re),
        .m1_req_valid(mv[1]), .m1_req_ready(m1_rdy), .m1_req_addr(ma[1]), .m1_req_wen(mwen[1]),
        .m1_req_wdata(mwd[1]), .m1_req_wstrb(mws[1]), .m1_rsp_valid(m1_rv), .m1_rsp_ready(mrr[1]),
        .m1_rsp_rdata(m1_rd), .m1_rsp_err(m1_re),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
        .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata), .s_req_wstrb(s_req_wstrb),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .s_rsp_err(s_rsp_err),
        .busy(busy), .grant(grant)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // slave behaviour knobs
    int          slv_lat = 2;
    bit          slv_never = 0;
    logic [31:0] slv_data = '0;
    logic        slv_err = 0;
    bit          spend = 0;
    int          swcnt = 0;
    logic        swen = 0;

    // observed handshakes and scoreboard
    logic [1:0]  req_hs_m = '0, rsp_hs_m = '0;
    logic        s_req_hs = 0, s_rsp_hs = 0, hs_wen = 0;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    int          served[$];
    logic [31:0] done_rd [2];
    logic        done_err [2];
    int          done_cyc [2];
    int          ndone [2];
    int          m0_rdy_during_m1 = 0;

    // reference model: who owns the bus and how far its transaction has got
    int cur = -1;
    bit gnt = 0, last = 1, issued = 0, tmo = 0, twen = 0;
    int waited = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic finish_txn(input int g);
        cur = -1; last = g[0]; issued = 0; tmo = 0;
    endtask

    always @(negedge clk) begin
        logic [1:0]  e_rdy, e_rv;
        logic        e_srv, e_srr, e_err;
        logic [31:0] e_rd;
        int g;
        if (!rst) begin
            cur = -1; gnt = 0; last = 1; issued = 0; tmo = 0; waited = 0;
            chk("rst_busy", busy, 0);
            chk("rst_grant", grant, 0);
            chk("rst_s_req_valid", s_req_valid, 0);
            chk("rst_s_rsp_ready", s_rsp_ready, 1);
            chk("rst_req_ready", mrdy, 0);
            chk("rst_rsp_valid", mrv, 0);
            chk("rst_rsp_err", mre, 0);
            chk("rst_rsp_rdata", mrd, 0);
            req_hs_m = '0; rsp_hs_m = '0; s_req_hs = 0; s_rsp_hs = 0;
        end else begin
            g = int'(gnt);
            e_rdy = '0; e_rv = '0; e_srv = 0; e_srr = 0; e_err = 0; e_rd = '0;
            if (cur < 0) begin
                e_srr = 1;
            end else if (!issued) begin
                e_srv = mv[g];
                e_rdy[g] = s_req_ready;
            end else if (!tmo) begin
                e_rv[g] = s_rsp_valid;
                e_srr = mrr[g];
                e_err = s_rsp_err;
                e_rd = (twen || s_rsp_err) ? 32'h0 : s_rsp_rdata;
            end else begin
                e_rv[g] = 1; e_err = 1;
            end
            chk("busy", busy, cur >= 0);
            if (cur >= 0) chk("grant", grant, gnt);
            chk("s_req_valid", s_req_valid, e_srv);
            if (e_srv) begin
                chk("s_req_addr", s_req_addr, ma[g]);
                chk("s_req_wen", s_req_wen, mwen[g]);
                chk("s_req_wdata", s_req_wdata, mwd[g]);
                chk("s_req_wstrb", s_req_wstrb, mws[g]);
            end
            chk("req_ready", mrdy, e_rdy);
            chk("rsp_valid", mrv, e_rv);
            chk("s_rsp_ready", s_rsp_ready, e_srr);
            for (int m = 0; m < 2; m++) begin
                if (e_rv[m]) begin
                    chk("rsp_rdata", mrd[m*32 +: 32], e_rd);
                    chk("rsp_err", mre[m], e_err);
                end
            end
            if (cur >= 0 && gnt && mrdy[0]) m0_rdy_during_m1++;

            // record what actually happened on the wires
            s_req_hs = s_req_valid && s_req_ready;
            s_rsp_hs = s_rsp_valid && s_rsp_ready;
            if (s_req_hs) begin
                hs_wen = s_req_wen; cap_addr = s_req_addr;
                cap_wdata = s_req_wdata; cap_wstrb = s_req_wstrb;
            end
            for (int m = 0; m < 2; m++) begin
                req_hs_m[m] = mv[m] && mrdy[m];
                rsp_hs_m[m] = mrv[m] && mrr[m];
                if (rsp_hs_m[m]) begin
                    served.push_back(m);
                    done_rd[m] = mrd[m*32 +: 32];
                    done_err[m] = mre[m];
                    done_cyc[m] = cyc;
                    ndone[m]++;
                end
            end

            // advance the model
            if (cur < 0) begin
                if (mv != 2'b00) begin
                    gnt = (mv == 2'b11) ? ~last : mv[1];
                    cur = int'(gnt);
                end
            end else if (!issued) begin
                if (mv[g] && s_req_ready) begin
                    issued = 1; waited = 0; twen = mwen[g];
                end else if (!mv[g]) begin
                    cur = -1;
                end
            end else if (!tmo) begin
                if (s_rsp_valid && mrr[g]) finish_txn(g);
                else if (!s_rsp_valid) begin
                    waited++;
                    if (waited == TO) tmo = 1;
                end
            end else if (mrr[g]) begin
                finish_txn(g);
            end
        end
        cyc++;
    end

    // master request release and slave response generation
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            s_rsp_valid = 0; spend = 0;
        end else begin
            for (int m = 0; m < 2; m++) if (req_hs_m[m]) mv[m] = 0;
            if (s_rsp_hs) s_rsp_valid = 0;
            if (s_req_hs) begin
                spend = 1; swcnt = slv_lat; swen = hs_wen;
            end
            if (spend && !slv_never) begin
                if (swcnt <= 1) begin
                    s_rsp_valid = 1;
                    s_rsp_rdata = swen ? 32'h0 : slv_data;
                    s_rsp_err = slv_err;
                    spend = 0;
                end else begin
                    swcnt--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int m, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s);
        mv[m] = 1; ma[m] = a; mwen[m] = w; mwd[m] = d; mws[m] = s;
    endtask

    task automatic wait_done(input int m, input int target, input string nm);
        int k = 0;
        while (ndone[m] < target && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_cmp++;
        if (ndone[m] < target) begin
            n_fail++;
            $display("FAIL %s: response count %0d expected %0d (timed out)", nm, ndone[m], target);
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    initial begin
        int c0, t0, t1, nsum;
        logic [31:0] a_tmp;
        mv = '0; mwen = '0; mrr = 2'b11;
        for (int m = 0; m < 2; m++) begin
            ma[m] = '0; mwd[m] = '0; mws[m] = '0;
            done_rd[m] = '0; done_err[m] = 0; done_cyc[m] = 0; ndone[m] = 0;
        end
        s_req_ready = 1; s_rsp_valid = 0; s_rsp_rdata = '0; s_rsp_err = 0;
        rst = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1;

        // single IFU read with 2-cycle slave response
        slv_lat = 2; slv_data = 32'h0000_0413;
        tick();
        set_req(0, 32'h8000_0000, 0, 32'h0, 4'h0);
        c0 = cyc;
        wait_done(0, 1, "t1_done");
        chk("t1_rdata", done_rd[0], 32'h0000_0413);
        chk("t1_err", done_err[0], 0);
        chk("t1_latency", done_cyc[0] - c0, 3);

        // simultaneous requests alternate after reset
        do_reset();
        served.delete();
        slv_lat = 1; slv_data = 32'h1111_2222;
        for (int r = 0; r < 2; r++) begin
            t0 = ndone[0] + 1; t1 = ndone[1] + 1;
            tick();
            set_req(0, 32'h8000_0100, 0, 32'h0, 4'h0);
            set_req(1, 32'h8000_0200, 0, 32'h0, 4'h0);
            wait_done(0, t0, "t2_m0_done");
            wait_done(1, t1, "t2_m1_done");
        end
        chk("t2_count", served.size(), 4);
        if (served.size() == 4) begin
            chk("t2_order0", served[0], 0);
            chk("t2_order1", served[1], 1);
            chk("t2_order2", served[2], 0);
            chk("t2_order3", served[3], 1);
        end

        // LSU write while IFU waits
        m0_rdy_during_m1 = 0;
        t0 = ndone[0] + 1; t1 = ndone[1] + 1;
        tick();
        set_req(1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF);
        tick();
        set_req(0, 32'h8000_0040, 0, 32'h0, 4'h0);
        wait_done(1, t1, "t3_m1_done");
        chk("t3_s_addr", cap_addr, 32'h8000_1000);
        chk("t3_s_wdata", cap_wdata, 32'hDEAD_BEEF);
        chk("t3_s_wstrb", cap_wstrb, 4'hF);
        chk("t3_s_wen", hs_wen, 1);
        chk("t3_err", done_err[1], 0);
        chk("t3_rdata", done_rd[1], 0);
        chk("t3_m0_held", m0_rdy_during_m1, 0);
        wait_done(0, t0, "t3_m0_done");
        chk("t3_m0_after", served[served.size()-1], 0);

        // slave never answers: timeout error, then a stray response is swallowed
        slv_never = 1;
        t0 = ndone[0] + 1;
        tick();
        set_req(0, 32'h8000_2000, 0, 32'h0, 4'h0);
        c0 = cyc;
        wait_done(0, t0, "t4_done");
        chk("t4_err", done_err[0], 1);
        chk("t4_rdata", done_rd[0], 0);
        chk("t4_latency", done_cyc[0] - c0, 6);
        tick();
        nsum = ndone[0] + ndone[1];
        s_rsp_valid = 1; s_rsp_rdata = 32'h1234_5678; s_rsp_err = 0;
        slv_never = 0; spend = 0;
        tick();
        tick();
        chk("t4_stray", ndone[0] + ndone[1], nsum);

        // master back-pressure on the response
        slv_lat = 1; slv_data = 32'hCAFE_0001;
        mrr[0] = 0;
        t0 = ndone[0] + 1;
        tick();
        set_req(0, 32'h8000_3000, 0, 32'h0, 4'h0);
        begin
            int k = 0;
            do begin
                @(negedge clk);
                #1;
                k++;
            end while (!m0_rv && k < 30);
        end
        for (int h = 0; h < 3; h++) begin
            if (h > 0) begin
                @(negedge clk);
                #1;
            end
            chk("t5_rsp_valid", m0_rv, 1);
            chk("t5_s_rsp_ready", s_rsp_ready, 0);
            chk("t5_rdata_stable", m0_rd, 32'hCAFE_0001);
        end
        tick();
        mrr[0] = 1;
        wait_done(0, t0, "t5_done");
        chk("t5_rdata", done_rd[0], 32'hCAFE_0001);

        // asynchronous reset in the middle of a response wait
        slv_lat = 3;
        tick();
        set_req(0, 32'h8000_4000, 0, 32'h0, 4'h0);
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("t6_in_resp", busy, 1);
        rst = 0;
        #1;
        chk("t6_busy_now", busy, 0);
        chk("t6_rsp_valid_now", m0_rv, 0);
        chk("t6_s_rsp_ready_now", s_rsp_ready, 1);
        nsum = ndone[0];
        tick();
        tick();
        rst = 1;
        t1 = ndone[1] + 1;
        tick();
        a_tmp = 32'h8000_5000;
        set_req(1, a_tmp, 0, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t6_grant_m1", grant, 1);
        wait_done(1, t1, "t6_m1_done");
        chk("t6_aborted_no_rsp", ndone[0], nsum);
        chk("t6_m1_served", served[served.size()-1], 1);

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
